// File: rtl/status_flags_unit_pkg.sv
// Shared types and constants for the ToastCPU status flag register.
// The flag word order is {I,X,N,Z,C,V} with V in bit 0.
package status_flags_unit_pkg;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_X = 4;
  localparam int FLAG_I = 5;
  localparam int FLAG_W = 6;

  typedef struct packed {
    logic i;
    logic x;
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [3:0] {
    COND_AL = 4'h0,
    COND_EQ = 4'h1,
    COND_NE = 4'h2,
    COND_CS = 4'h3,
    COND_CC = 4'h4,
    COND_MI = 4'h5,
    COND_PL = 4'h6,
    COND_VS = 4'h7,
    COND_VC = 4'h8,
    COND_HI = 4'h9,
    COND_LS = 4'hA,
    COND_GE = 4'hB,
    COND_LT = 4'hC,
    COND_GT = 4'hD,
    COND_LE = 4'hE,
    COND_XS = 4'hF
  } cond_code_t;

endpackage

// File: rtl/status_flags_unit_flag_shadow_stack.sv
// Register-array LIFO holding flag frames saved on interrupt entry.
// Pushes while full and pops while empty are ignored.
module flag_shadow_stack
  import status_flags_unit_pkg::*;
#(
  parameter int SHADOW_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] push_data,
  output logic [FLAG_W-1:0] top_data,
  output logic [3:0]        count,
  output logic              full,
  output logic              empty
);

  logic [FLAG_W-1:0] mem_q [SHADOW_DEPTH];
  logic [FLAG_W-1:0] mem_d [SHADOW_DEPTH];
  logic [3:0]        count_q, count_d;

  assign count = count_q;
  assign full  = (count_q == 4'(SHADOW_DEPTH));
  assign empty = (count_q == 4'd0);

  always_comb begin
    top_data = '0;
    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (count_q == 4'(i + 1)) top_data = mem_q[i];
    end
  end

  // The slot written by a push is the one indexed by the current count.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < SHADOW_DEPTH; i++) mem_d[i] = mem_q[i];
    if (push && !full) begin
      for (int i = 0; i < SHADOW_DEPTH; i++) begin
        if (count_q == 4'(i)) mem_d[i] = push_data;
      end
      count_d = count_q + 4'd1;
    end else if (pop && !empty) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 4'd0;
      for (int i = 0; i < SHADOW_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < SHADOW_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/status_flags_unit.sv
// Architectural status register: flag capture with event priority, interrupt
// shadow stack, sticky stack errors and branch condition evaluation.
module status_flags_unit
  import status_flags_unit_pkg::*;
#(
  parameter int SHADOW_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic        alu_V,
  input  logic        alu_C,
  input  logic        alu_N,
  input  logic        alu_Z,
  input  logic        alu_X,
  input  logic        alu_set_VC,
  input  logic        flags_we,
  input  logic [5:0]  flags_wdata,
  input  logic        irq_enter,
  input  logic        irq_return,
  input  logic        err_clear,
  input  logic [3:0]  cond_code,
  output logic        cond_true,
  output logic [5:0]  flags,
  output logic        carry_out,
  output logic [3:0]  shadow_count,
  output logic        shadow_overflow,
  output logic        shadow_underflow
);

  flags_t            flags_q, flags_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [FLAG_W-1:0] stk_top;

  flag_shadow_stack #(.SHADOW_DEPTH(SHADOW_DEPTH)) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (flags_q),
    .top_data  (stk_top),
    .count     (shadow_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Only the highest-priority event acts; a new error beats err_clear.
  always_comb begin
    flags_d     = flags_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    overflow_d  = overflow_q & ~err_clear;
    underflow_d = underflow_q & ~err_clear;
    if (irq_enter) begin
      stk_push  = ~stk_full;
      if (stk_full) overflow_d = 1'b1;
      flags_d.i = 1'b0;
    end else if (irq_return) begin
      if (stk_empty) begin
        underflow_d = 1'b1;
      end else begin
        stk_pop = 1'b1;
        flags_d = flags_t'(stk_top);
      end
    end else if (flags_we) begin
      flags_d = flags_t'(flags_wdata);
    end else if (alu_valid) begin
      flags_d.n = alu_N;
      flags_d.z = alu_Z;
      flags_d.x = alu_X;
      if (alu_set_VC) begin
        flags_d.v = alu_V;
        flags_d.c = alu_C;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    cond_true = 1'b1;
    case (cond_code_t'(cond_code))
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = flags_q.z;
      COND_NE: cond_true = ~flags_q.z;
      COND_CS: cond_true = flags_q.c;
      COND_CC: cond_true = ~flags_q.c;
      COND_MI: cond_true = flags_q.n;
      COND_PL: cond_true = ~flags_q.n;
      COND_VS: cond_true = flags_q.v;
      COND_VC: cond_true = ~flags_q.v;
      COND_HI: cond_true = flags_q.c & ~flags_q.z;
      COND_LS: cond_true = ~flags_q.c | flags_q.z;
      COND_GE: cond_true = (flags_q.n == flags_q.v);
      COND_LT: cond_true = (flags_q.n != flags_q.v);
      COND_GT: cond_true = ~flags_q.z & (flags_q.n == flags_q.v);
      COND_LE: cond_true = flags_q.z | (flags_q.n != flags_q.v);
      COND_XS: cond_true = flags_q.x;
      default: cond_true = 1'b1;
    endcase
  end

  assign flags            = flags_q;
  assign carry_out        = flags_q.c;
  assign shadow_overflow  = overflow_q;
  assign shadow_underflow = underflow_q;

endmodule

// File: tb/tb_status_flags_unit.sv
// Scoreboard bench for status_flags_unit: a reference model predicts each
// cycle's flags/stack state, predictions are queued and compared after the edge.
module tb_status_flags_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_valid, alu_V, alu_C, alu_N, alu_Z, alu_X, alu_set_VC;
  logic       flags_we;
  logic [5:0] flags_wdata;
  logic       irq_enter, irq_return, err_clear;
  logic [3:0] cond_code;
  logic       cond_true;
  logic [5:0] flags;
  logic       carry_out;
  logic [3:0] shadow_count;
  logic       shadow_overflow, shadow_underflow;

  status_flags_unit #(.SHADOW_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .alu_valid        (alu_valid),
    .alu_V            (alu_V),
    .alu_C            (alu_C),
    .alu_N            (alu_N),
    .alu_Z            (alu_Z),
    .alu_X            (alu_X),
    .alu_set_VC       (alu_set_VC),
    .flags_we         (flags_we),
    .flags_wdata      (flags_wdata),
    .irq_enter        (irq_enter),
    .irq_return       (irq_return),
    .err_clear        (err_clear),
    .cond_code        (cond_code),
    .cond_true        (cond_true),
    .flags            (flags),
    .carry_out        (carry_out),
    .shadow_count     (shadow_count),
    .shadow_overflow  (shadow_overflow),
    .shadow_underflow (shadow_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] flags;
    logic [3:0] count;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       expQ[$];
  logic [5:0] mFlags;
  logic [5:0] mStack [8];
  int         mCount;
  logic       mOvf, mUnf;
  int         checks = 0;
  int         failures = 0;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic refCond(input logic [3:0] code, input logic [5:0] f);
    logic v, c, z, n, x;
    v = f[0]; c = f[1]; z = f[2]; n = f[3]; x = f[4];
    case (code)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return c;
      4'h4: return !c;
      4'h5: return n;
      4'h6: return !n;
      4'h7: return v;
      4'h8: return !v;
      4'h9: return c && !z;
      4'hA: return !(c && !z);
      4'hB: return !(n ^ v);
      4'hC: return n ^ v;
      4'hD: return !z && !(n ^ v);
      4'hE: return !(!z && !(n ^ v));
      default: return x;
    endcase
  endfunction

  task automatic idleInputs();
    alu_valid = 0; alu_V = 0; alu_C = 0; alu_N = 0; alu_Z = 0; alu_X = 0;
    alu_set_VC = 0; flags_we = 0; flags_wdata = '0;
    irq_enter = 0; irq_return = 0; err_clear = 0;
  endtask

  task automatic modelReset();
    mFlags = '0; mCount = 0; mOvf = 0; mUnf = 0;
    expQ.delete();
  endtask

  // alu is {V,C,N,Z,X}; one clock of stimulus, prediction and comparison.
  task automatic applyStimulus(input string tag, input logic ent, input logic ret,
                               input logic we, input logic [5:0] wd,
                               input logic av, input logic svc, input logic [4:0] alu,
                               input logic clr);
    logic [5:0] nf;
    logic       nOvf, nUnf;
    exp_t       e;
    @(negedge clk);
    irq_enter = ent; irq_return = ret; flags_we = we; flags_wdata = wd;
    alu_valid = av; alu_set_VC = svc;
    {alu_V, alu_C, alu_N, alu_Z, alu_X} = alu;
    err_clear = clr;
    nf = mFlags; nOvf = mOvf && !clr; nUnf = mUnf && !clr;
    if (ent) begin
      if (mCount < DEPTH) begin
        mStack[mCount] = mFlags;
        mCount++;
      end else nOvf = 1;
      nf[5] = 0;
    end else if (ret) begin
      if (mCount > 0) begin
        mCount--;
        nf = mStack[mCount];
      end else nUnf = 1;
    end else if (we) nf = wd;
    else if (av) begin
      nf[4] = alu[0]; nf[3] = alu[2]; nf[2] = alu[1];
      if (svc) begin nf[1] = alu[3]; nf[0] = alu[4]; end
    end
    mFlags = nf; mOvf = nOvf; mUnf = nUnf;
    expQ.push_back('{flags: nf, count: 4'(mCount), ovf: nOvf, unf: nUnf});
    @(posedge clk);
    #1;
    idleInputs();
    e = expQ.pop_front();
    checkOutput({tag, ".flags"}, 8'(flags), 8'(e.flags));
    checkOutput({tag, ".count"}, 8'(shadow_count), 8'(e.count));
    checkOutput({tag, ".ovf"}, 8'(shadow_overflow), 8'(e.ovf));
    checkOutput({tag, ".unf"}, 8'(shadow_underflow), 8'(e.unf));
    checkOutput({tag, ".carry"}, 8'(carry_out), 8'(e.flags[1]));
  endtask

  task automatic loadFlags(input string tag, input logic [5:0] v);
    applyStimulus(tag, 0, 0, 1, v, 0, 0, 5'b0, 0);
  endtask

  task automatic checkCond(input string tag, input logic [3:0] code, input logic req);
    cond_code = code;
    #1;
    checkOutput(tag, 8'(cond_true), 8'(req));
  endtask

  initial begin
    idleInputs();
    cond_code = 4'h0;
    reset_n = 0;
    modelReset();
    #12;
    checkOutput("rst.flags", 8'(flags), 8'h00);
    checkOutput("rst.count", 8'(shadow_count), 8'h00);
    checkOutput("rst.ovf", 8'(shadow_overflow), 8'h00);
    checkOutput("rst.unf", 8'(shadow_underflow), 8'h00);
    @(negedge clk);
    reset_n = 1;

    applyStimulus("alu1", 0, 0, 0, 6'h00, 1, 1, 5'b11100, 0);
    checkOutput("alu1.lit", 8'(flags), 8'b001011);
    applyStimulus("alu2", 0, 0, 0, 6'h00, 1, 0, 5'b00010, 0);
    checkOutput("alu2.lit", 8'(flags), 8'b000111);

    loadFlags("cond.ld", 6'b001001);
    checkCond("cond.GE", 4'hB, 1'b1);
    checkCond("cond.LT", 4'hC, 1'b0);
    checkCond("cond.GT", 4'hD, 1'b1);
    checkCond("cond.LE", 4'hE, 1'b0);
    checkCond("cond.MI", 4'h5, 1'b1);
    checkCond("cond.EQ", 4'h1, 1'b0);
    for (int f = 0; f < 64; f++) begin
      loadFlags("sweep.ld", 6'(f));
      for (int c = 0; c < 16; c++) checkCond($sformatf("sweep.f%0h.c%0h", f, c), 4'(c), refCond(4'(c), 6'(f)));
    end

    for (int k = 0; k < DEPTH; k++) begin
      loadFlags("nest.ld", 6'h20 | 6'(k * 5 + 1));
      applyStimulus($sformatf("nest.push%0d", k), 1, 0, 0, 6'h00, 0, 0, 5'b0, 0);
    end
    checkOutput("nest.count4", 8'(shadow_count), 8'd4);
    loadFlags("nest.ld5", 6'h3F);
    applyStimulus("nest.ovf", 1, 0, 0, 6'h00, 0, 0, 5'b0, 0);
    checkOutput("nest.ovf.lit", 8'({shadow_overflow, flags[5]}), 8'b10);
    for (int k = 0; k < DEPTH; k++)
      applyStimulus($sformatf("nest.pop%0d", k), 0, 1, 0, 6'h00, 0, 0, 5'b0, 0);
    checkOutput("nest.lastpop", 8'(flags), 8'h21);
    applyStimulus("nest.unf", 0, 1, 0, 6'h00, 0, 0, 5'b0, 0);
    applyStimulus("clr", 0, 0, 0, 6'h00, 0, 0, 5'b0, 1);

    loadFlags("b2b.ld", 6'h25);
    applyStimulus("b2b.push0", 1, 0, 0, 6'h00, 0, 0, 5'b0, 0);
    applyStimulus("b2b.push1", 1, 0, 0, 6'h00, 0, 0, 5'b0, 0);
    applyStimulus("b2b.pop1", 0, 1, 0, 6'h00, 0, 0, 5'b0, 0);
    checkOutput("b2b.frame1", 8'(flags), 8'h05);
    applyStimulus("b2b.pop0", 0, 1, 0, 6'h00, 0, 0, 5'b0, 0);

    applyStimulus("sim.all", 1, 1, 0, 6'h00, 1, 1, 5'b11111, 0);
    checkOutput("sim.all.count", 8'(shadow_count), 8'd1);
    applyStimulus("sim.we_alu", 0, 0, 1, 6'h2A, 1, 1, 5'b11111, 0);
    for (int k = 0; k < DEPTH - 1; k++)
      applyStimulus("sim.fill", 1, 0, 0, 6'h00, 0, 0, 5'b0, 0);
    applyStimulus("sim.ovf_clr", 1, 0, 0, 6'h00, 0, 0, 5'b0, 1);
    checkOutput("sim.ovf_clr.lit", 8'(shadow_overflow), 8'd1);
    applyStimulus("sim.ret_we", 0, 1, 1, 6'h3F, 0, 0, 5'b0, 0);

    loadFlags("arst.ld", 6'h3F);
    #2;
    reset_n = 0;
    #1;
    checkOutput("arst.flags", 8'(flags), 8'h00);
    checkOutput("arst.count", 8'(shadow_count), 8'h00);
    checkOutput("arst.ovf", 8'(shadow_overflow), 8'h00);
    checkOutput("arst.unf", 8'(shadow_underflow), 8'h00);
    modelReset();
    @(negedge clk);
    reset_n = 1;
    applyStimulus("arst.after", 0, 1, 0, 6'h00, 0, 0, 5'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_flags_unit.md
# status_flags_unit

Architectural status register for ToastCPU, directly downstream of the ALU. It captures the V/C/N/Z/X flags the ALU produces and holds the interrupt-enable bit. It saves and restores flags across interrupt entry and return through a small shadow stack. It evaluates branch condition codes against the registered flags and feeds the registered carry back to the ALU `carry_in`.

## Interface
Parameters:
- `SHADOW_DEPTH`, default 4: number of nested interrupt flag frames; legal range 1–8.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `alu_valid`  in  1: ALU result this cycle is architecturally committed; flags are captured.
- `alu_V`, `alu_C`, `alu_N`, `alu_Z`, `alu_X`  in  1 each: ALU flag outputs.
- `alu_set_VC`  in  1: when 1, V and C are updated; when 0, V and C are held.
- `flags_we`  in  1: explicit load of the whole flag word, for move-to-status.
- `flags_wdata`  in  6: data for `flags_we`.
- `irq_enter`  in  1: single-cycle pulse; push flags and clear I.
- `irq_return`  in  1: single-cycle pulse; pop flags.
- `err_clear`  in  1: clears the sticky error bits.
- `cond_code`  in  4: branch condition selector.
- `cond_true`  out  1: condition result, combinational from registered flags.
- `flags`  out  6: registered flag word, bit order {I,X,N,Z,C,V} = [5:0].
- `carry_out`  out  1: equals `flags[1]`, wired to ALU `carry_in`.
- `shadow_count`  out  4: number of occupied stack frames.
- `shadow_overflow`  out  1: sticky; set when a push was dropped.
- `shadow_underflow`  out  1: sticky; set when a pop hit an empty stack.

## Operation
- Reset values: `flags`=6'b000000 (I=0), `shadow_count`=0, both sticky bits 0, stack contents don't-care.
- Per-cycle update priority, highest first: `irq_enter` > `irq_return` > `flags_we` > `alu_valid`. Only the highest asserted event takes effect. Lower events in the same cycle are discarded with no error.
- `alu_valid` update:
  - N, Z, X always load from the ALU.
  - V and C load only if `alu_set_VC`=1.
  - I is never touched.
- `flags_we`: all 6 bits load from `flags_wdata`.
- `irq_enter`:
  - If `shadow_count` < `SHADOW_DEPTH`: push the current `flags` (pre-update) and increment the count.
  - Else: do not push, set `shadow_overflow`, and keep the count and the existing frames.
  - In both cases, next `flags` = current flags with I=0.
- `irq_return`:
  - If `shadow_count` > 0: `flags` ← top frame (all 6 bits, including I) and decrement the count.
  - Else: set `shadow_underflow` and leave `flags` unchanged.
- `err_clear`: clears both sticky bits. If a new error occurs in the same cycle, the set wins.
- `cond_true` by `cond_code`:
  - 0 AL = 1
  - 1 EQ = Z; 2 NE = !Z
  - 3 CS = C; 4 CC = !C
  - 5 MI = N; 6 PL = !N
  - 7 VS = V; 8 VC = !V
  - 9 HI = C&!Z; A LS = !C|Z
  - B GE = N==V; C LT = N!=V
  - D GT = !Z&(N==V); E LE = Z|(N!=V)
  - F XS = X

## Timing
- Flag updates are registered. A result committed in cycle t is visible on `flags`, `carry_out` and `cond_true` in cycle t+1.
- There is no forwarding. A branch in cycle t+1 sees the flags of the commit in cycle t.
- `cond_true` is purely combinational from `flags` and `cond_code`, with zero latency.
- Push/pop latency is 1 cycle. Back-to-back `irq_enter` pulses on consecutive cycles each push one frame. The second push saves the flags with I=0.
- `reset_n` deassertion mid-nest discards all frames immediately; there is no drain.
- `shadow_count` and the sticky bits update on the same edge as the event that causes them.

## Structure
- A shared package holds:
  - flag bit index constants (FLAG_V=0 … FLAG_I=5)
  - the `cond_code_t` enum (AL…XS)
  - the `flags_t` packed struct
- The ALU flag port ordering stays unchanged.
- Sub-module `flag_shadow_stack`:
  - parameterised `SHADOW_DEPTH`, 6-bit-wide register-array LIFO
  - ports: push, pop, push_data, top_data, count, full, empty
  - it never pushes when full and never pops when empty
- The top-level module holds priority selection, the flag register, sticky errors and the condition decode.

## Test plan
- Reset mid-operation: load `flags_we` with 6'h3F, then assert `reset_n`=0 asynchronously → `flags`=0, `shadow_count`=0 and stickies 0 without waiting for a clock edge.
- ALU capture:
  - `alu_valid`, V=1 C=1 N=1 Z=0 X=0, `alu_set_VC`=1 → next cycle `flags`=6'b001011.
  - Then `alu_valid` with `alu_set_VC`=0, V=0 C=0 Z=1 N=0 → `flags`=6'b000111.
- Conditions: with `flags`=6'b001001 (N=1, V=1):
  - GE=1, LT=0, GT=1, LE=0, MI=1, EQ=0.
  - Sweep all 16 codes against a reference model over 64 flag values.
- Nesting: set I=1 and push 4 frames with distinct flags → `shadow_count`=4. A 5th `irq_enter` sets `shadow_overflow` and I=0. Four returns restore the frames in LIFO order. A 5th return sets `shadow_underflow` and leaves flags unchanged.
- Simultaneous events:
  - `irq_enter`+`irq_return`+`alu_valid` in one cycle → only the push happens; `shadow_count` +1.
  - `flags_we`+`alu_valid` → `flags_wdata` wins.
  - `err_clear` with a concurrent overflow → the sticky bit stays 1.
